// File: rtl/spi_frame_ctrl.sv
// SPI slave frame decoder: R/W bit, 7-bit address and 8-bit data, MSB first,
// producing register-bank write/read strobes and serial readback on poci.
//
// state    | meaning
// WAIT_CSB | after reset, ignore bits until csb is seen high
// IDLE     | between frames, next csb-low edge is edge 0 (R/W bit)
// ADDR     | shifting address bits (edges 1..ADDR_W)
// DATA     | shifting write data or driving readback (remaining edges)
// DONE     | frame complete, trailing bits ignored until csb rises
module spi_frame_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              spi_clk,
  input  logic              rstn,
  input  logic              csb,
  input  logic              pico,
  input  logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              is_write,
  output logic              wr_strobe,
  output logic              rd_strobe,
  output logic              poci,
  output logic              busy,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(ADDR_W + DATA_W + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DATA_FIRST = CNT_W'(ADDR_W + 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(ADDR_W + DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  localparam logic [2:0] S_WAIT_CSB = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_ADDR     = 3'd2;
  localparam logic [2:0] S_DATA     = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-2:0] addr_sh;
  logic [DATA_W-2:0] data_sh;
  logic [DATA_W-2:0] shadow;

  assign busy = (state == S_ADDR) || (state == S_DATA) || (state == S_DONE);

  always_ff @(posedge spi_clk) begin
    if (!rstn) begin
      state     <= S_WAIT_CSB;
      bit_cnt   <= '0;
      addr_sh   <= '0;
      data_sh   <= '0;
      shadow    <= '0;
      addr      <= '0;
      wdata     <= '0;
      is_write  <= 1'b0;
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      poci      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      case (state)
        S_WAIT_CSB: begin
          if (csb) state <= S_IDLE;
        end
        S_IDLE: begin
          if (!csb) begin
            state     <= S_ADDR;
            is_write  <= pico;
            frame_err <= 1'b0;
            bit_cnt   <= CNT_W'(1);
          end
        end
        S_ADDR: begin
          if (csb) begin
            state     <= S_IDLE;
            frame_err <= 1'b1;
            poci      <= 1'b0;
          end else begin
            if (bit_cnt == ADDR_LAST) begin
              addr      <= {addr_sh, pico};
              rd_strobe <= !is_write;
              state     <= S_DATA;
            end else begin
              addr_sh <= {addr_sh[ADDR_W-3:0], pico};
            end
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (csb) begin
            state     <= S_IDLE;
            frame_err <= 1'b1;
            poci      <= 1'b0;
          end else begin
            if (is_write) begin
              if (bit_cnt == DATA_LAST) begin
                wdata     <= {data_sh, pico};
                wr_strobe <= 1'b1;
              end else begin
                data_sh <= {data_sh[DATA_W-3:0], pico};
              end
            end else if (bit_cnt == DATA_FIRST) begin
              // rdata is valid here because addr was loaded on the previous edge
              poci   <= rdata[DATA_W-1];
              shadow <= rdata[DATA_W-2:0];
            end else begin
              poci   <= shadow[DATA_W-2];
              shadow <= {shadow[DATA_W-3:0], 1'b0};
            end
            if (bit_cnt == DATA_LAST) state <= S_DONE;
            if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          poci <= 1'b0;
          if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CNT_W'(1);
          if (csb) state <= S_IDLE;
        end
        default: state <= S_WAIT_CSB;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Bench for spi_frame_ctrl: table of frames with expected register state,
// plus a strobe/readback scoreboard and reset corner sequences.
module tb_spi_frame_ctrl;

  logic       clk = 1'b0;
  logic       rstn, csb, pico;
  logic [7:0] rdata;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       is_write, wr_strobe, rd_strobe, poci, busy, frame_err;

  spi_frame_ctrl dut (
    .spi_clk(clk), .rstn(rstn), .csb(csb), .pico(pico), .rdata(rdata),
    .addr(addr), .wdata(wdata), .is_write(is_write), .wr_strobe(wr_strobe),
    .rd_strobe(rd_strobe), .poci(poci), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] bits;
    int          nbits;
    logic [7:0]  rd;
    logic [6:0]  e_addr;
    logic [7:0]  e_wdata;
    logic        e_w;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic       w;
    logic [6:0] a;
    logic [7:0] d;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic c, input logic p);
    csb  = c;
    pico = p;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pops an expected frame on each strobe, gathers readback bits.
  initial begin
    exp_t       e;
    logic [7:0] got;
    forever begin
      @(negedge clk);
      check("strobe_overlap", {31'd0, wr_strobe & rd_strobe}, 0);
      if (wr_strobe || rd_strobe) begin
        check("sb_underflow", {31'd0, sb.size() == 0}, 0);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("strobe_kind", {31'd0, wr_strobe}, {31'd0, e.w});
          check("strobe_addr", {25'd0, addr}, {25'd0, e.a});
          if (wr_strobe) check("strobe_wdata", {24'd0, wdata}, {24'd0, e.d});
        end
        check("poci_idle", {31'd0, poci}, 0);
        if (rd_strobe) begin
          for (int k = 7; k >= 0; k--) begin
            @(negedge clk);
            got[k] = poci;
          end
          check("poci_byte", {24'd0, got}, {24'd0, e.d});
        end
      end else begin
        check("poci_idle", {31'd0, poci}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, {25'd0, addr}, 0);
    check({tag, "_wdata"}, {24'd0, wdata}, 0);
    check({tag, "_flags"}, {26'd0, is_write, wr_strobe, rd_strobe, poci, busy, frame_err}, 0);
  endtask

  initial begin
    vecs[0] = '{20'h083A5, 16, 8'h00, 7'h03, 8'hA5, 1'b1, 1'b0};
    vecs[1] = '{20'h00500, 16, 8'h3C, 7'h05, 8'hA5, 1'b0, 1'b0};
    vecs[2] = '{20'h0020A, 10, 8'h00, 7'h02, 8'hA5, 1'b1, 1'b1};
    vecs[3] = '{20'h81F0F, 20, 8'h00, 7'h01, 8'hF0, 1'b1, 1'b0};
    vecs[4] = '{20'h0FF01, 16, 8'h00, 7'h7F, 8'h01, 1'b1, 1'b0};
    vecs[5] = '{20'h07F00, 16, 8'h96, 7'h7F, 8'h01, 1'b0, 1'b0};
    vecs[6] = '{20'h00001,  5, 8'h00, 7'h7F, 8'h01, 1'b0, 1'b1};
    vecs[7] = '{20'h00001,  1, 8'h00, 7'h7F, 8'h01, 1'b1, 1'b1};
    vecs[8] = '{20'h08000, 16, 8'h00, 7'h00, 8'h00, 1'b1, 1'b0};
    vecs[9] = '{20'h02A00, 16, 8'h81, 7'h2A, 8'h00, 1'b0, 1'b0};

    rstn = 1'b0; csb = 1'b0; pico = 1'b0; rdata = 8'h00;
    tick(0, 1);
    tick(0, 1);
    check_all_zero("reset");

    // Released with csb low: bits must be ignored until csb is seen high.
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(0, i[0]);
      check("post_reset_busy", {31'd0, busy}, 0);
    end
    check_all_zero("post_reset");
    tick(1, 0);

    foreach (vecs[n]) begin
      rdata = vecs[n].rd;
      check("pre_busy", {31'd0, busy}, 0);
      if (vecs[n].nbits >= 16)
        sb.push_back('{vecs[n].e_w, vecs[n].e_addr, vecs[n].e_w ? vecs[n].e_wdata : vecs[n].rd});
      for (int i = vecs[n].nbits - 1; i >= 0; i--) tick(0, vecs[n].bits[i]);
      check("frame_busy", {31'd0, busy}, 1);
      tick(1, 0);
      check("post_busy", {31'd0, busy}, 0);
      check("addr", {25'd0, addr}, {25'd0, vecs[n].e_addr});
      check("wdata", {24'd0, wdata}, {24'd0, vecs[n].e_wdata});
      check("is_write", {31'd0, is_write}, {31'd0, vecs[n].e_w});
      check("frame_err", {31'd0, frame_err}, {31'd0, vecs[n].e_err});
    end

    // Reset at edge 9 of a write frame, released with csb still low.
    begin
      logic [15:0] f;
      f = 16'h84CC;
      for (int i = 15; i >= 7; i--) tick(0, f[i]);
      rstn = 1'b0;
      tick(0, f[6]);
      rstn = 1'b1;
      check_all_zero("midreset");
      for (int i = 5; i >= 0; i--) tick(0, f[i]);
      for (int i = 0; i < 4; i++) tick(0, 1);
      check_all_zero("midreset_hold");
      tick(1, 0);
      sb.push_back('{1'b1, 7'h04, 8'hCC});
      for (int i = 15; i >= 0; i--) tick(0, f[i]);
      tick(1, 0);
      check("midreset_addr", {25'd0, addr}, 32'h04);
      check("midreset_wdata", {24'd0, wdata}, 32'hCC);
      check("midreset_err", {31'd0, frame_err}, 0);
    end

    tick(1, 0);
    tick(1, 0);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
